// File: rtl/hazard_detect_unit_pkg.sv
// hazard_detect_unit_pkg: shared pipeline encodings and instruction field helpers
package hazard_detect_unit_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALTED = 2'd2} state_t;
  localparam int RD_HI = 11;
  localparam int RS_HI = 7;
  localparam int RT_HI = 3;
  localparam logic [3:0] REG_ZERO = 4'b0000;
  function automatic logic [3:0] field(input logic [15:0] inst, input int hi);
    return inst[hi -: 4];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter for performance monitoring
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: ID-stage load-use stall, branch flush and halt control
module hazard_detect_unit
  import hazard_detect_unit_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      inst_ifid,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             uses_rd_id,
  input  logic [3:0]       rf_waddr_idex,
  input  logic             mem_read_idex,
  input  logic             branch_taken_ex,
  input  logic             halt_id,
  input  logic             resume,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [3:0] STALL_INIT = 4'(LOAD_USE_STALLS - 1);
  state_t state;
  logic [3:0] rem;
  logic lu, redirect, hold;
  always_comb begin
    lu = mem_read_idex && rf_waddr_idex != REG_ZERO &&
         ((uses_rs_id && field(inst_ifid, RS_HI) == rf_waddr_idex) ||
          (uses_rt_id && field(inst_ifid, RT_HI) == rf_waddr_idex) ||
          (uses_rd_id && field(inst_ifid, RD_HI) == rf_waddr_idex));
    redirect = branch_taken_ex && state != HALTED;
    // a taken branch overrides any stall; HALTED and STALL freeze regardless of lu
    hold = !redirect && (state != RUN || lu);
    pc_wen = !hold;
    ifid_wen = !hold;
    ifid_flush = redirect;
    idex_bubble = redirect || hold;
    halted = state == HALTED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      rem <= '0;
    end else begin
      case (state)
        RUN:
          if (!branch_taken_ex) begin
            if (lu) begin
              if (LOAD_USE_STALLS > 1) begin
                state <= STALL;
                rem <= STALL_INIT;
              end
            end else if (halt_id) state <= HALTED;
          end
        STALL:
          if (branch_taken_ex) begin
            state <= RUN;
            rem <= '0;
          end else begin
            rem <= rem - 1'b1;
            if (rem == 4'd1) state <= RUN;
          end
        HALTED: if (resume) state <= RUN;
        default: state <= RUN;
      endcase
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .inc(!pc_wen),
    .count(stall_cycles)
  );
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: table-driven scoreboard bench for two parameterisations
module tb_hazard_detect_unit;
  logic clk = 0, rst_n = 0;
  logic [15:0] inst_ifid;
  logic uses_rs_id, uses_rt_id, uses_rd_id, mem_read_idex, branch_taken_ex, halt_id, resume;
  logic [3:0] rf_waddr_idex;
  logic p1, i1, f1, b1, h1, p3, i3, f3, b3, h3;
  logic [15:0] c1;
  logic [3:0] c3;
  int checks = 0, failures = 0;

  typedef struct {
    bit sel3;
    logic [15:0] inst;
    logic [2:0] uses;
    logic [3:0] wa;
    logic mr, br, hlt, res;
    logic [4:0] exp;
    int cnt;
  } vec_t;
  vec_t tbl[$];
  vec_t sbq[$];

  always #5 clk = ~clk;

  hazard_detect_unit #(.LOAD_USE_STALLS(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .inst_ifid(inst_ifid), .uses_rs_id(uses_rs_id),
    .uses_rt_id(uses_rt_id), .uses_rd_id(uses_rd_id), .rf_waddr_idex(rf_waddr_idex),
    .mem_read_idex(mem_read_idex), .branch_taken_ex(branch_taken_ex), .halt_id(halt_id),
    .resume(resume), .pc_wen(p1), .ifid_wen(i1), .ifid_flush(f1), .idex_bubble(b1),
    .halted(h1), .stall_cycles(c1));
  hazard_detect_unit #(.LOAD_USE_STALLS(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .inst_ifid(inst_ifid), .uses_rs_id(uses_rs_id),
    .uses_rt_id(uses_rt_id), .uses_rd_id(uses_rd_id), .rf_waddr_idex(rf_waddr_idex),
    .mem_read_idex(mem_read_idex), .branch_taken_ex(branch_taken_ex), .halt_id(halt_id),
    .resume(resume), .pc_wen(p3), .ifid_wen(i3), .ifid_flush(f3), .idex_bubble(b3),
    .halted(h3), .stall_cycles(c3));

  function automatic vec_t mk(bit s, logic [15:0] inst, logic [2:0] uses, logic [3:0] wa,
                              logic mr, logic br, logic hlt, logic res, logic [4:0] exp, int cnt);
    vec_t v;
    v.sel3 = s; v.inst = inst; v.uses = uses; v.wa = wa; v.mr = mr; v.br = br;
    v.hlt = hlt; v.res = res; v.exp = exp; v.cnt = cnt;
    return v;
  endfunction

  task automatic zero_inputs();
    inst_ifid = '0; {uses_rs_id, uses_rt_id, uses_rd_id} = '0; rf_waddr_idex = '0;
    mem_read_idex = 0; branch_taken_ex = 0; halt_id = 0; resume = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    zero_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic check_out(input int idx);
    vec_t e;
    logic [4:0] got;
    int gc;
    e = sbq.pop_front();
    got = e.sel3 ? {p3, i3, f3, b3, h3} : {p1, i1, f1, b1, h1};
    gc = e.sel3 ? int'(c3) : int'(c1);
    checks += 2;
    if (got !== e.exp) begin
      failures++;
      $display("FAIL vec%0d dut%0d outputs{pc,ifid,flush,bubble,halted} got=%b exp=%b",
               idx, e.sel3 ? 3 : 1, got, e.exp);
    end
    if (gc != e.cnt) begin
      failures++;
      $display("FAIL vec%0d dut%0d stall_cycles got=%0d exp=%0d", idx, e.sel3 ? 3 : 1, gc, e.cnt);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    @(negedge clk);
    inst_ifid = v.inst;
    {uses_rs_id, uses_rt_id, uses_rd_id} = v.uses;
    rf_waddr_idex = v.wa; mem_read_idex = v.mr; branch_taken_ex = v.br;
    halt_id = v.hlt; resume = v.res;
    sbq.push_back(v);
    #4 check_out(idx);
  endtask

  task automatic run_tbl(input int base);
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], base + i);
    tbl.delete();
  endtask

  initial begin
    zero_inputs();
    do_reset();
    // single-stall config: load-use, r0, non-load, priority against halt/branch
    tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 0));
    tbl.push_back(mk(0, 16'h0030, 3'b100, 3, 1, 0, 0, 0, 5'b00010, 0));
    tbl.push_back(mk(0, 16'h0030, 3'b100, 0, 0, 0, 0, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 16'h0000, 3'b100, 0, 1, 0, 0, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 16'h0005, 3'b010, 5, 0, 0, 0, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 16'h0035, 3'b010, 3, 1, 0, 0, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, 1, 1, 0, 5'b11110, 1));
    tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 1));
    tbl.push_back(mk(0, 16'h0030, 3'b100, 3, 1, 0, 1, 0, 5'b00010, 1));
    tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 2));
    tbl.push_back(mk(0, 16'h0030, 3'b100, 3, 1, 1, 0, 0, 5'b11110, 2));
    run_tbl(0);
    do_reset();
    // three-stall config: rd hazard, branch during stall, lu+branch, unused rd
    tbl.push_back(mk(1, 16'h0700, 3'b001, 7, 1, 0, 0, 0, 5'b00010, 0));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b00010, 1));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b00010, 2));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 3));
    tbl.push_back(mk(1, 16'h0700, 3'b001, 7, 1, 0, 0, 0, 5'b00010, 3));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 1, 0, 0, 5'b11110, 4));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 4));
    tbl.push_back(mk(1, 16'h0700, 3'b001, 7, 1, 1, 0, 0, 5'b11110, 4));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 4));
    tbl.push_back(mk(1, 16'h0700, 3'b110, 7, 1, 0, 0, 0, 5'b11000, 4));
    run_tbl(100);
    do_reset();
    // halt for 10 frozen cycles, branches ignored, resume in the last one
    tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, 0, 1, 0, 5'b11000, 0));
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, (k % 3) == 0, 0, k == 10, 5'b00011, k - 1));
    tbl.push_back(mk(0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 10));
    run_tbl(200);
    do_reset();
    // 4-bit counter saturation, then asynchronous reset inside STALL
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 1, 0, 5'b11000, 0));
    for (int k = 1; k <= 20; k++)
      tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, k == 20, 5'b00011, (k - 1 > 15) ? 15 : k - 1));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 15));
    tbl.push_back(mk(1, 16'h0700, 3'b001, 7, 1, 0, 0, 0, 5'b00010, 15));
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b00010, 15));
    run_tbl(300);
    @(negedge clk);
    checks++;
    if ({p3, i3, f3, b3, h3} !== 5'b00010) begin
      failures++;
      $display("FAIL pre_reset_stall got=%b exp=00010", {p3, i3, f3, b3, h3});
    end
    rst_n = 0;
    #1;
    checks += 2;
    if ({p3, i3, f3, b3, h3} !== 5'b11000) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b exp=11000", {p3, i3, f3, b3, h3});
    end
    if (c3 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_counter got=%0d exp=0", c3);
    end
    @(negedge clk);
    rst_n = 1;
    tbl.push_back(mk(1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 5'b11000, 0));
    run_tbl(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
